// File: rtl/data_cache.sv
// Direct-mapped, write-back, one-word-per-line data cache between the MEM stage and a
// ready-handshaked data memory. Misses stall the core while the FSM writes back and refills.
module data_cache #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LINES = 8
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [3:0][7:0] cpu_wdata,
  input  logic            cpu_read,
  input  logic            cpu_write,
  output logic [3:0][7:0] cpu_rdata,
  output logic            stall,
  output logic            reg_write_enable_cache,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  input  logic            mem_ready_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned IDXW = $clog2(LINES);
  localparam int unsigned TAGW = XLEN - IDXW - 2;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWriteback = 2'd1;
  localparam logic [1:0] StRefill    = 2'd2;
  localparam logic [1:0] StDone      = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [XLEN-1:0]  data_q [LINES];

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            victim_dirty;
  logic            is_write;
  logic            is_read;
  logic            store_we;
  logic            fill_we;
  logic            clean_we;
  logic [1:0]      unused_addr_bits;

  assign idx              = cpu_addr[IDXW+1:2];
  assign tag              = cpu_addr[XLEN-1:IDXW+2];
  assign unused_addr_bits = cpu_addr[1:0];
  assign hit              = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty     = valid_q[idx] && dirty_q[idx];
  // A simultaneous read and write is a store.
  assign is_write         = cpu_write;
  assign is_read          = cpu_read && !cpu_write;

  always_comb begin
    state_d                = state_q;
    stall                  = 1'b0;
    reg_write_enable_cache = 1'b0;
    cpu_rdata              = '0;
    mem_addr_o             = '0;
    mem_wdata_o            = '0;
    mem_read_o             = 1'b0;
    mem_write_o            = 1'b0;
    store_we               = 1'b0;
    fill_we                = 1'b0;
    clean_we               = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_write || is_read) begin
          if (hit) begin
            if (is_write) begin
              store_we = 1'b1;
            end else begin
              cpu_rdata = data_q[idx];
            end
          end else if (victim_dirty) begin
            stall   = 1'b1;
            state_d = StWriteback;
          end else if (is_write) begin
            store_we = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = StRefill;
          end
        end
      end
      StWriteback: begin
        stall       = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {tag_q[idx], idx, 2'b00};
        mem_wdata_o = data_q[idx];
        if (mem_ready_i) begin
          clean_we = 1'b1;
          state_d  = is_write ? StDone : StRefill;
        end
      end
      StRefill: begin
        stall      = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = {cpu_addr[XLEN-1:2], 2'b00};
        if (mem_ready_i) begin
          fill_we = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (is_write) begin
          store_we = 1'b1;
        end else if (is_read) begin
          cpu_rdata              = data_q[idx];
          reg_write_enable_cache = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset is immediate: quiet every output and block any pending line update.
    if (rst_b) begin
      state_d                = StIdle;
      stall                  = 1'b0;
      reg_write_enable_cache = 1'b0;
      cpu_rdata              = '0;
      mem_addr_o             = '0;
      mem_wdata_o            = '0;
      mem_read_o             = 1'b0;
      mem_write_o            = 1'b0;
      store_we               = 1'b0;
      fill_we                = 1'b0;
      clean_we               = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (store_we) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b1;
      end else if (fill_we) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (clean_we) begin
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag and data need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (store_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= cpu_wdata;
    end else if (fill_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a wait-state memory model plus scoreboards for load
// results, write-backs and refill addresses, with directed timing checks.
module tb_data_cache;

  logic            clk = 1'b0;
  logic            rst_b = 1'b1;
  logic [31:0]     cpu_addr = '0;
  logic [3:0][7:0] cpu_wdata = '0;
  logic            cpu_read = 1'b0;
  logic            cpu_write = 1'b0;
  logic [3:0][7:0] cpu_rdata;
  logic            stall;
  logic            reg_write_enable_cache;
  logic [31:0]     mem_addr_o;
  logic [31:0]     mem_wdata_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            mem_ready_i = 1'b0;
  logic [31:0]     mem_rdata_i = '0;

  data_cache #(
    .XLEN  (32),
    .LINES (8)
  ) dut (
    .clk                    (clk),
    .rst_b                  (rst_b),
    .cpu_addr               (cpu_addr),
    .cpu_wdata              (cpu_wdata),
    .cpu_read               (cpu_read),
    .cpu_write              (cpu_write),
    .cpu_rdata              (cpu_rdata),
    .stall                  (stall),
    .reg_write_enable_cache (reg_write_enable_cache),
    .mem_addr_o             (mem_addr_o),
    .mem_wdata_o            (mem_wdata_o),
    .mem_read_o             (mem_read_o),
    .mem_write_o            (mem_write_o),
    .mem_ready_i            (mem_ready_i),
    .mem_rdata_i            (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        pulse;
  } rd_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_exp_t;

  rd_exp_t     rd_exp_q[$];
  wb_exp_t     wb_exp_q[$];
  logic [31:0] rf_exp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory responder and output monitor; ready is decided first so the monitor sees the
  // handshake that completes at the coming rising edge.
  always @(negedge clk) begin
    rd_exp_t e_rd;
    wb_exp_t e_wb;
    logic [31:0] e_rf;
    if (rst_b || !(mem_read_o || mem_write_o)) begin
      mem_ready_i = 1'b0;
      wcnt = 0;
    end else if (wcnt == wait_cfg) begin
      mem_ready_i = 1'b1;
      wcnt = 0;
      if (mem_read_o) begin
        mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
      end
    end else begin
      mem_ready_i = 1'b0;
      wcnt++;
    end

    if (!rst_b) begin
      if (mem_write_o && mem_ready_i) begin
        if (wb_exp_q.size() == 0) begin
          check_eq("wb_unexpected", mem_addr_o, 32'hffff_ffff);
        end else begin
          e_wb = wb_exp_q.pop_front();
          check_eq("wb_addr", mem_addr_o, e_wb.addr);
          check_eq("wb_data", mem_wdata_o, e_wb.data);
        end
        mem_model[mem_addr_o] = mem_wdata_o;
      end
      if (mem_read_o && mem_ready_i) begin
        if (rf_exp_q.size() == 0) begin
          check_eq("rf_unexpected", mem_addr_o, 32'hffff_ffff);
        end else begin
          e_rf = rf_exp_q.pop_front();
          check_eq("rf_addr", mem_addr_o, e_rf);
        end
      end
      if (cpu_read && !cpu_write && !stall) begin
        if (rd_exp_q.size() == 0) begin
          check_eq("rd_unexpected", cpu_rdata, 32'hffff_ffff);
        end else begin
          e_rd = rd_exp_q.pop_front();
          check_eq("rd_data", cpu_rdata, e_rd.data);
          check_eq("rd_pulse", {31'b0, reg_write_enable_cache}, {31'b0, e_rd.pulse});
        end
      end
    end
  end

  // Holds a request until the core would advance; returns stall cycles and memory activity.
  task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic rd,
                           input logic wr, output int unsigned stall_cyc, output logic traffic);
    bit done;
    done      = 1'b0;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_read  = rd;
    cpu_write = wr;
    stall_cyc = 0;
    traffic   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      traffic |= (mem_read_o | mem_write_o);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stall_cyc++;
    end
    if (!done) check_eq("access_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] d, input logic pulse,
                             output int unsigned stall_cyc, output logic traffic);
    rd_exp_q.push_back('{data: d, pulse: pulse});
    do_access(a, 32'h0, 1'b1, 1'b0, stall_cyc, traffic);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sc;
    logic        tr;

    mem_model[32'h40]  = 32'hDEAD_BEEF;
    mem_model[32'h60]  = 32'hCAFE_F00D;
    mem_model[32'h24]  = 32'hA5A5_5A5A;
    mem_model[32'h100] = 32'h0101_0101;
    mem_model[32'h140] = 32'h1357_2468;

    // Reset held with a pending read: every output must stay quiet.
    cpu_addr = 32'h40;
    cpu_read = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_rwe", {31'b0, reg_write_enable_cache}, 32'd0);
    check_eq("rst_mem_req", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    check_eq("rst_mem_addr", mem_addr_o, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata_o, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    rst_b    = 1'b0;
    @(posedge clk);
    #1;

    // Cold read miss with three wait cycles.
    wait_cfg = 3;
    rf_exp_q.push_back(32'h40);
    expect_read(32'h40, 32'hDEAD_BEEF, 1'b1, sc, tr);
    check_eq("miss_stall_cycles", sc, 32'd5);
    @(negedge clk);
    check_eq("rwe_single_cycle", {31'b0, reg_write_enable_cache}, 32'd0);
    @(posedge clk);
    #1;

    expect_read(32'h40, 32'hDEAD_BEEF, 1'b0, sc, tr);
    check_eq("reread_stall", sc, 32'd0);
    check_eq("reread_traffic", {31'b0, tr}, 32'd0);

    // Store hit, then read it back.
    do_access(32'h40, 32'h1122_3344, 1'b0, 1'b1, sc, tr);
    check_eq("wr_hit_stall", sc, 32'd0);
    check_eq("wr_hit_traffic", {31'b0, tr}, 32'd0);
    expect_read(32'h40, 32'h1122_3344, 1'b0, sc, tr);
    check_eq("wr_hit_readback_stall", sc, 32'd0);

    // Conflict read miss over a dirty victim: write-back then refill.
    wait_cfg = 1;
    wb_exp_q.push_back('{addr: 32'h40, data: 32'h1122_3344});
    rf_exp_q.push_back(32'h60);
    expect_read(32'h60, 32'hCAFE_F00D, 1'b1, sc, tr);
    check_eq("dirty_miss_stall", sc, 32'd5);

    // Write miss to an invalid line installs without memory traffic.
    wait_cfg = 0;
    do_access(32'h04, 32'h0BAD_CAFE, 1'b0, 1'b1, sc, tr);
    check_eq("wr_miss_stall", sc, 32'd0);
    check_eq("wr_miss_traffic", {31'b0, tr}, 32'd0);
    expect_read(32'h04, 32'h0BAD_CAFE, 1'b0, sc, tr);
    check_eq("wr_miss_readback_stall", sc, 32'd0);
    wb_exp_q.push_back('{addr: 32'h04, data: 32'h0BAD_CAFE});
    rf_exp_q.push_back(32'h24);
    expect_read(32'h24, 32'hA5A5_5A5A, 1'b1, sc, tr);
    check_eq("evict_installed_stall", sc, 32'd3);

    // Reset in the middle of a refill.
    wait_cfg  = 5;
    cpu_addr  = 32'h100;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    @(negedge clk);
    check_eq("abort_miss_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    check_eq("abort_refill_req", {31'b0, mem_read_o}, 32'd1);
    check_eq("abort_refill_addr", mem_addr_o, 32'h100);
    #1;
    rst_b = 1'b1;
    #1;
    check_eq("abort_req_drop", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    check_eq("abort_stall_drop", {31'b0, stall}, 32'd0);
    check_eq("abort_addr_drop", mem_addr_o, 32'd0);
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    rst_b    = 1'b0;
    @(posedge clk);
    #1;
    wait_cfg = 0;
    rf_exp_q.push_back(32'h100);
    expect_read(32'h100, 32'h0101_0101, 1'b1, sc, tr);
    check_eq("post_abort_miss_stall", sc, 32'd2);

    // Read and write together on a hit behave as a store.
    cpu_addr  = 32'h100;
    cpu_wdata = 32'h7766_5544;
    cpu_read  = 1'b1;
    cpu_write = 1'b1;
    @(negedge clk);
    check_eq("rw_stall", {31'b0, stall}, 32'd0);
    check_eq("rw_rwe", {31'b0, reg_write_enable_cache}, 32'd0);
    check_eq("rw_traffic", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    check_eq("rw_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    wb_exp_q.push_back('{addr: 32'h100, data: 32'h7766_5544});
    rf_exp_q.push_back(32'h140);
    expect_read(32'h140, 32'h1357_2468, 1'b1, sc, tr);
    check_eq("rw_evict_stall", sc, 32'd3);

    repeat (2) @(posedge clk);
    check_eq("rd_q_drained", rd_exp_q.size(), 32'd0);
    check_eq("wb_q_drained", wb_exp_q.size(), 32'd0);
    check_eq("rf_q_drained", rf_exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back data cache placed between the pipelined core's MEM stage and the multi-cycle data memory. It serves MEM-stage loads and stores, stalls the pipeline on misses, and performs dirty write-back and line refill through a ready-handshaked memory port. It reports refill-completed loads back to the core via `reg_write_enable_cache`.

## Interface
- `XLEN`, 32: data/address width.
- `LINES`, 8: number of one-word cache lines; power of two; `IDXW = log2(LINES)`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_b`  in  1  reset, asynchronous, active-high.
- `cpu_addr`  in  XLEN  MEM-stage byte address; bits [1:0] ignored.
- `cpu_wdata`  in  4x8  store data; `[0]` is bits 7:0 of the word.
- `cpu_read`  in  1  load request.
- `cpu_write`  in  1  store request.
- `cpu_rdata`  out  4x8  load data; `[0]` is bits 7:0 of the word.
- `stall`  out  1  freeze the pipeline; the core holds its request stable while high.
- `reg_write_enable_cache`  out  1  one-cycle pulse: the stalled load's data is valid this cycle.
- `mem_addr_o`  out  XLEN  word-aligned memory address.
- `mem_wdata_o`  out  XLEN  write-back data.
- `mem_read_o`  out  1  refill request.
- `mem_write_o`  out  1  write-back request.
- `mem_ready_i`  in  1  memory completes the current request this cycle.

## Operation
- Address split: index = `cpu_addr[IDXW+1:2]`; tag = `cpu_addr[XLEN-1:IDXW+2]`.
- Each line holds valid, dirty, tag, and a 32-bit word.
- Hit = valid and tag match.
- If `cpu_read` and `cpu_write` are both high, the request is treated as a write.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
- IDLE:
  - No request: nothing happens.
  - Read hit: `cpu_rdata` = line word (combinational), `stall`=0.
  - Write hit: word written, dirty set at the edge, `stall`=0.
  - Write miss, victim clean or invalid: line installed directly (valid=1, dirty=1, new tag, `cpu_wdata`); no stall, no memory traffic.
  - Read miss, victim clean or invalid: `stall`=1, go to REFILL.
  - Any miss with a valid dirty victim: `stall`=1, go to WRITEBACK.
- WRITEBACK:
  - Drives `mem_write_o`=1, `mem_addr_o`={victim tag, index, 2'b00}, `mem_wdata_o`=victim word; `stall`=1.
  - On `mem_ready_i`: clear dirty; go to REFILL if the request is a read, DONE if a write.
- REFILL:
  - Drives `mem_read_o`=1, `mem_addr_o`={`cpu_addr[XLEN-1:2]`, 2'b00}; `stall`=1.
  - On `mem_ready_i`: capture the memory word into the line (valid=1, dirty=0, new tag); go to DONE.
  - Returned read data is bus input `mem_rdata_i`  in  XLEN (part of the memory port).
- DONE:
  - `stall`=0; go to IDLE.
  - Read: `cpu_rdata` = line word, `reg_write_enable_cache`=1.
  - Write: install `cpu_wdata` with valid=1, dirty=1, new tag.
- `mem_ready_i` is ignored in IDLE and DONE.
- Memory outputs are 0 outside WRITEBACK/REFILL.
- `cpu_rdata` is 0 when there is neither a read hit nor a read in DONE.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; all valid and dirty bits cleared.
  - `stall`, `reg_write_enable_cache`, `mem_read_o`, `mem_write_o` = 0; `mem_addr_o`, `mem_wdata_o`, `cpu_rdata` = 0.
  - Reset mid-WRITEBACK/REFILL aborts the transaction; no line is updated.
- Hit latency: 0 cycles. Read data is valid in the request cycle; a store commits at the end of that cycle.
- `stall` is combinational from IDLE-state miss detection, so it is high in the miss-detect cycle.
- Read miss, clean victim, memory ready on first request cycle:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: REFILL, `mem_read_o`=1, `mem_ready_i`=1.
  - Cycle 2: DONE, `stall`=0, pulse.
- Each memory wait cycle adds exactly one cycle.
- Dirty read miss adds WRITEBACK cycles before REFILL.
- Memory requests are held constant until the `mem_ready_i` edge and deassert in the following cycle.
- Back-to-back accesses to the same line after DONE hit.
- Same-index different-tag accesses conflict-evict.

## Test plan
- Reset, then read 0x0000_0040 with memory returning 0xDEADBEEF after 3 wait cycles.
  - Required: `stall` high 5 cycles, `mem_addr_o`=0x40, then DONE with `cpu_rdata`=EF,BE,AD,DE and `reg_write_enable_cache` high exactly 1 cycle.
  - Required: an immediate re-read of 0x40 hits with no stall.
- Write 0x11223344 to 0x40 (resident).
  - Required: no stall, no memory traffic; a later read returns 0x11223344.
- With 0x40 dirty, read 0x0000_0060 (same index for LINES=8).
  - Required: WRITEBACK with `mem_addr_o`=0x40, `mem_wdata_o`=0x11223344; then REFILL at 0x60; the read returns the memory value.
- Write miss to an invalid line at 0x0000_0004.
  - Required: no stall; a later read returns the stored word; evicting it triggers a write-back.
- Assert `rst_b` during REFILL.
  - Required: memory requests drop immediately; state is IDLE; a re-read of the same address misses.
- Assert `cpu_read`=`cpu_write`=1 on a hit.
  - Required: the request is treated as a store; the line becomes dirty and `reg_write_enable_cache`=0.
